// File: rtl/pc_pkg.sv
// Shared types for the program counter: operation encoding and the priority decoder
// that turns the active-low/active-high control pins into a single operation.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_OP_HOLD,
        PC_OP_LOAD,
        PC_OP_CALL,
        PC_OP_RET,
        PC_OP_REL,
        PC_OP_INC
    } pc_op_t;

    // Fixed priority: load > call > ret > rel > count > hold.
    function automatic pc_op_t pc_decode(input logic loadn,
                                         input logic calln,
                                         input logic retn,
                                         input logic reln,
                                         input logic count);
        pc_op_t op;
        if (!loadn)      op = PC_OP_LOAD;
        else if (!calln) op = PC_OP_CALL;
        else if (!retn)  op = PC_OP_RET;
        else if (!reln)  op = PC_OP_REL;
        else if (count)  op = PC_OP_INC;
        else             op = PC_OP_HOLD;
        return op;
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Return-address LIFO for the program counter. Push and pop are ignored when the
// stack is full or empty respectively; push wins if both are requested.
module pc_return_stack
    import pc_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [STACK_DEPTH];
    logic [SP_W-1:0]  sp_q, sp_d;
    logic [IDX_W-1:0] wr_idx, top_idx;
    logic             do_push, do_pop;

    assign full_o  = (sp_q == SP_W'(STACK_DEPTH));
    assign empty_o = (sp_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o && !do_push;
    assign wr_idx  = IDX_W'(sp_q);
    assign top_idx = IDX_W'(sp_q - SP_W'(1));
    assign top_o   = mem_q[top_idx];

    always_comb begin
        sp_d = sp_q;
        if (do_push)     sp_d = sp_q + SP_W'(1);
        else if (do_pop) sp_d = sp_q - SP_W'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sp_q <= '0;
        else         sp_q <= sp_d;
    end

    // Entries above the stack pointer are don't-care, so the storage needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_idx] <= data_i;
    end

endmodule

// File: rtl/pc_stack_counter.sv
// Program counter with load, relative branch, increment and call/return.
// The return stack is built only when PC_STACK_EN is defined.
module pc_stack_counter
    import pc_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter int               OFS_WIDTH   = 8,
    parameter int               STEP        = 1,
    parameter int               STACK_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_VEC   = '0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 outn,
    input  logic                 loadn,
    input  logic                 count,
    input  logic                 reln,
    input  logic                 calln,
    input  logic                 retn,
    inout  wire logic [WIDTH-1:0] abus,
    input  logic [OFS_WIDTH-1:0] dbus,
    output logic                 full,
    output logic                 empty,
    output logic                 err
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_inc, pc_rel, ofs_ext;
    logic [WIDTH-1:0] stack_top;
    logic             stack_full, stack_empty;
    logic             calln_eff, retn_eff;
    pc_op_t           op;

    assign ofs_ext = WIDTH'($signed(dbus));
    assign pc_inc  = pc_q + STEP_W;
    assign pc_rel  = pc_q + ofs_ext;
    assign op      = pc_decode(loadn, calln_eff, retn_eff, reln, count);

`ifdef PC_STACK_EN
    logic err_q, err_d;

    assign calln_eff = calln;
    assign retn_eff  = retn;

    pc_return_stack #(
        .WIDTH       (WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (op == PC_OP_CALL),
        .pop_i   (op == PC_OP_RET),
        .data_i  (pc_inc),
        .top_o   (stack_top),
        .full_o  (stack_full),
        .empty_o (stack_empty)
    );

    assign err_d = err_q
                 | ((op == PC_OP_CALL) && stack_full)
                 | ((op == PC_OP_RET)  && stack_empty);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) err_q <= 1'b0;
        else         err_q <= err_d;
    end

    assign err = err_q;
`else
    logic unused_stack_pins;

    assign unused_stack_pins = calln ^ retn;
    assign calln_eff         = 1'b1;
    assign retn_eff          = 1'b1;
    assign stack_top         = '0;
    assign stack_full        = 1'b0;
    assign stack_empty       = 1'b1;
    assign err               = 1'b0;
`endif

    assign full  = stack_full;
    assign empty = stack_empty;

    // A refused call (full) or return (empty) leaves the PC where it was.
    always_comb begin
        pc_d = pc_q;
        case (op)
            PC_OP_LOAD: pc_d = abus;
            PC_OP_CALL: pc_d = stack_full  ? pc_q : abus;
            PC_OP_RET:  pc_d = stack_empty ? pc_q : stack_top;
            PC_OP_REL:  pc_d = pc_rel;
            PC_OP_INC:  pc_d = pc_inc;
            default:    pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) pc_q <= RESET_VEC;
        else         pc_q <= pc_d;
    end

    assign abus = (!outn && loadn && calln_eff) ? pc_q : 'z;

endmodule

// File: doc/pc_stack_counter.md
# pc_stack_counter

Parametrised program counter for the CPU core and emulator: drives the shared address bus and supports increment, absolute load, signed relative branch, and hardware call/return through an internal return-address stack. It is the successor to the fixed 16-bit counter. It runs on a single clock; the separate inverted-clock secondary stage is removed, and all state updates on the rising edge.

## Interface
- WIDTH, 16: address width in bits; PC arithmetic is modulo 2^WIDTH.
- OFS_WIDTH, 8: width of the signed relative-branch offset.
- STEP, 1: increment applied by count and used to form call return addresses.
- STACK_DEPTH, 4: return-stack entries, ≥1.
- RESET_VEC, 0: PC value after reset.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- outn  in  1  active-low output enable onto abus.
- loadn  in  1  active-low absolute load from abus.
- count  in  1  active-high increment by STEP.
- reln  in  1  active-low relative branch: PC += sign-extended dbus.
- calln  in  1  active-low call: push PC+STEP, then PC ← abus.
- retn  in  1  active-low return: PC ← popped entry.
- abus  inout  WIDTH  address bus.
- dbus  in  OFS_WIDTH  two's-complement branch offset.
- full  out  1  stack holds STACK_DEPTH entries.
- empty  out  1  stack holds no entries.
- err  out  1  sticky stack overflow/underflow flag.

## Operation
- Operation per edge, fixed priority: load > call > ret > rel > count > hold. At most one operation executes per edge; lower-priority requests in the same cycle are dropped.
- load: PC ← abus.
- call, stack not full:
  - push (PC+STEP) mod 2^WIDTH;
  - PC ← abus.
- call, stack full: PC and stack unchanged; err ← 1.
- ret, stack not empty: PC ← top entry; pop.
- ret, stack empty: PC unchanged; err ← 1.
- rel: PC ← (PC + sext(dbus)) mod 2^WIDTH. Wraps in both directions: 0x0000 + (−1) = 0xFFFF.
- count: PC ← (PC + STEP) mod 2^WIDTH. 0xFFFF + 1 = 0x0000.
- err clears only on reset.
- Bus drive: abus = PC when outn=0 and loadn=1 and calln=1; otherwise high-Z.
  - With outn=0 and loadn=0 (or calln=0) together, the block releases the bus and samples the external value.
  - The block never reads its own drive.
- full = (sp == STACK_DEPTH); empty = (sp == 0). Both are combinational from the stack pointer.

## Timing
- Asynchronous reset, effective immediately while resetn=0:
  - PC = RESET_VEC, sp = 0, err = 0, full = 0, empty = 1;
  - abus follows outn (reset value visible if outn=0).
- Reset release: the first operation executes on the first rising edge with resetn=1.
- Reset mid-call or mid-return: the edge's operation is discarded; the stack is emptied.
- Latency: one edge. The new PC appears on abus (when enabled) in the same cycle following the edge.
- outn → abus and full/empty are combinational, with zero cycles of latency.
- Control inputs and abus/dbus are sampled at the rising edge and must be stable around it.
- call and ret in the same cycle: call wins; no pop occurs.

## Configuration
- PC_STACK_EN defined: return stack, calln/retn, full/empty/err fully functional.
- PC_STACK_EN undefined:
  - no stack storage;
  - calln and retn ignored (treated as inactive);
  - full = 0, empty = 1, err = 0 constant.
  - Load/rel/count behaviour unchanged.

## Structure
- Shared package pc_pkg:
  - operation enum pc_op_t (PC_OP_HOLD, PC_OP_LOAD, PC_OP_CALL, PC_OP_RET, PC_OP_REL, PC_OP_INC);
  - priority-decode function mapping control inputs to pc_op_t.
- Sub-module pc_return_stack:
  - parametrised LIFO (WIDTH, STACK_DEPTH) with push/pop, full/empty, clk/resetn;
  - instantiated only under PC_STACK_EN.
- Top level holds the PC register, adder/sign-extend datapath, tri-state driver, and the sticky err flag.

## Test plan
WIDTH=16, STEP=1, STACK_DEPTH=4.
- Reset with outn=1 → abus = Z. Then outn=0 → abus = 0x0000, empty = 1, full = 0, err = 0.
- count=1 for 0x10000 edges from 0 → abus equals the edge index each cycle, then wraps to 0x0000.
- loadn=0 with external 0xBEEF, outn=0 → block releases abus, and after the edge PC = 0xBEEF. Then reln=0, dbus=0x80 → 0xBE6F; dbus=0x7F → 0xBEEE.
- From PC=0x1000, four calls to 0x2000/0x3000/0x4000/0x5000 → full = 1. A fifth call → PC stays 0x5000, err = 1. Four returns → PC = 0x4001, 0x3001, 0x2001, 0x1001, then empty = 1.
- Simultaneous loadn=0, calln=0, count=1 → load only, stack unchanged. Then assert resetn=0 during calln=0 → PC = 0, empty = 1, err = 0 immediately, with no push.
- PC_STACK_EN undefined: calln=0 with abus=0x1234 → PC increments only if count=1 and is otherwise held. full = 0, empty = 1, err = 0 throughout.
